kvt_proj_name_rr_arbiter: RTL and testbench

- Round-robin arbiter/scheduler that shares the single proj_name datapath input among NUM_REQ requesters.
- Grants ownership per burst (delimited by last) and muxes the owner's data onto the proj_name port through a valid/ready handshake.
- Instanced inside the proj_name wrapper between the requester-side agents and proj_name.

---
 rtl/kvt_proj_name_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_kvt_proj_name_rr_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kvt_proj_name_rr_arbiter.sv
// Round-robin burst arbiter sharing the proj_name datapath among NUM_REQ requesters.
// Optional stall watchdog enabled by defining KVT_PROJ_NAME_ARB_TIMEOUT_EN.
module kvt_proj_name_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        dut_valid,
  output logic                        dut_last,
  output logic [DATA_W-1:0]           dut_data,
  output logic [IDX_W-1:0]            dut_src,
  input  logic                        dut_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state, state_d;
  logic [IDX_W-1:0]     owner, owner_d;
  logic [IDX_W-1:0]     ptr, ptr_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic                 busy_d;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     cand;
  logic                 win_found;
  logic                 xfer;
  logic [DATA_W-1:0]    data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] stall_cnt, stall_cnt_d;
  logic             timeout_d;
  logic             stall_hit;

  assign stall_hit = (state == LOCK) && !xfer &&
                     (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  assign xfer = dut_valid && dut_ready;

  // First pending requester after the last-served index, with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // Owner's beat is muxed straight through; nothing is exposed while idle.
  always_comb begin
    dut_valid = 1'b0;
    dut_last  = 1'b0;
    dut_data  = '0;
    dut_src   = '0;
    req_ready = '0;
    if (state == LOCK) begin
      dut_valid        = req_valid[owner];
      dut_last         = req_last[owner];
      dut_data         = data_arr[owner];
      dut_src          = owner;
      req_ready[owner] = dut_ready;
    end
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    ptr_d   = ptr;
    grant_d = grant;
    busy_d  = busy;
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt;
    timeout_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
          state_d = LOCK;
          owner_d = win;
          grant_d = NUM_REQ'(1) << win;
          busy_d  = 1'b1;
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      LOCK: begin
        if (xfer && dut_last) begin
          state_d = IDLE;
          ptr_d   = owner;
          grant_d = '0;
          busy_d  = 1'b0;
        end
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
        else if (stall_hit) begin
          state_d   = IDLE;
          ptr_d     = owner;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
        stall_cnt_d = (xfer || stall_hit) ? '0 : stall_cnt + CNT_W'(1);
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= IDX_W'(NUM_REQ - 1);
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      ptr   <= ptr_d;
      grant <= grant_d;
      busy  <= busy_d;
    end
  end

`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      stall_cnt   <= stall_cnt_d;
      timeout_err <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_kvt_proj_name_rr_arbiter.sv
// Scoreboard bench for kvt_proj_name_rr_arbiter: queued requester beats, expected beats and grant order.
module tb_kvt_proj_name_rr_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 2;
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC  = 8;
`else
  localparam int unsigned TO_CYC  = 256;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_last = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      dut_valid, dut_last, busy;
  logic                      dut_ready = 1'b0;
  logic [DATA_W-1:0]         dut_data;
  logic [IDX_W-1:0]          dut_src;
  logic [NUM_REQ-1:0]        grant;
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
  logic                      timeout_err;
`endif

  always #5 clk = ~clk;

  kvt_proj_name_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .dut_valid(dut_valid), .dut_last(dut_last), .dut_data(dut_data),
    .dut_src(dut_src), .dut_ready(dut_ready),
    .grant(grant), .busy(busy)
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int total = 0;
  int bad = 0;
  logic [DATA_W:0]      beat_q [NUM_REQ][$];
  logic [DATA_W:0]      exp_q  [NUM_REQ][$];
  logic [NUM_REQ-1:0]   exp_grant_q[$];
  bit                   hold   [NUM_REQ];
  bit                   xfer_s [NUM_REQ];
  int                   xfer_cnt = 0;
  int                   idle_run = 0;
  int                   to_pulses = 0;
  bit                   check_gap = 1'b0;
  bit                   seen_burst = 1'b0;
  logic [NUM_REQ-1:0]   prev_grant = '0;

  // Requester agents: present queue heads, retire a beat after each handshake.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_s[i] && beat_q[i].size() > 0) void'(beat_q[i].pop_front());
      xfer_s[i] = 1'b0;
      if (!hold[i] && beat_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = beat_q[i][0][DATA_W];
        req_data[i*DATA_W +: DATA_W] = beat_q[i][0][DATA_W-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Monitor: beat scoreboard, grant order, one-hot ownership, idle gaps.
  always @(negedge clk) begin
    logic [DATA_W:0]    eb;
    logic [NUM_REQ-1:0] eg;
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) xfer_s[i] = req_valid[i] && req_ready[i];
      if (busy) begin
        total++;
        if (grant !== (NUM_REQ'(1) << dut_src) || (req_ready & ~grant) !== '0) begin
          bad++;
          $display("FAIL owner_onehot grant=%b src=%0d req_ready=%b", grant, dut_src, req_ready);
        end
      end
      if (dut_valid && dut_ready) begin
        xfer_cnt++;
        total++;
        if (exp_q[dut_src].size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat src=%0d data=%h", dut_src, dut_data);
        end else begin
          eb = exp_q[dut_src].pop_front();
          if ({dut_last, dut_data} !== eb) begin
            bad++;
            $display("FAIL beat src=%0d got last=%b data=%h exp last=%b data=%h",
                     dut_src, dut_last, dut_data, eb[DATA_W], eb[DATA_W-1:0]);
          end
        end
      end
      if (grant == '0) idle_run++;
      else if (prev_grant == '0) begin
        if (exp_grant_q.size() > 0) begin
          eg = exp_grant_q.pop_front();
          total++;
          if (grant !== eg) begin
            bad++;
            $display("FAIL grant_order got=%b exp=%b", grant, eg);
          end
        end
        if (check_gap && seen_burst) begin
          total++;
          if (idle_run !== 1) begin
            bad++;
            $display("FAIL idle_gap got=%0d exp=1", idle_run);
          end
        end
        seen_burst = 1'b1;
        idle_run = 0;
      end
      prev_grant = grant;
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
      if (timeout_err) to_pulses++;
`endif
    end else begin
      prev_grant = '0;
    end
  end

  task automatic push_beat(input int r, input logic [DATA_W-1:0] d, input logic l, input bit expect_it);
    beat_q[r].push_back({l, d});
    if (expect_it) exp_q[r].push_back({l, d});
  endtask

  task automatic wait_busy(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk); #2;
      if (busy) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s wait_busy timed out busy=%b", name, busy);
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = !busy;
      for (int i = 0; i < NUM_REQ; i++) if (exp_q[i].size() != 0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s drain timed out busy=%b", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dut_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (grant !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_state grant=%b busy=%b exp 0/0", grant, busy);
    end
    total++;
    if ({dut_valid, dut_last, dut_data, dut_src, req_ready} !== '0) begin
      bad++; $display("FAIL reset_outputs valid=%b last=%b data=%h src=%0d rdy=%b exp all 0",
                      dut_valid, dut_last, dut_data, dut_src, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000};
    dut_ready = 1'b1;
    check_gap = 1'b1;
    seen_burst = 1'b0;
    @(posedge clk); #2;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < NUM_REQ; r++) push_beat(r, DATA_W'(32'h100 + b*16 + r), 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) exp_grant_q.push_back(seq[k]);
    wait_drain("round_robin");
    check_gap = 1'b0;
    total++;
    if (exp_grant_q.size() !== 0) begin
      bad++; $display("FAIL rr_grants_left got=%0d exp=0", exp_grant_q.size());
      exp_grant_q.delete();
    end
  endtask

  task automatic test_single_burst();
    dut_ready = 1'b1;
    @(posedge clk); #2;
    push_beat(0, 32'hA0, 1'b0, 1'b1);
    push_beat(0, 32'hA1, 1'b0, 1'b1);
    push_beat(0, 32'hA2, 1'b1, 1'b1);
    exp_grant_q.push_back(4'b0001);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (grant !== '0) begin bad++; $display("FAIL arb_latency grant=%b exp=0000", grant); end
    @(negedge clk);
    total++;
    if (grant !== 4'b0001 || dut_data !== 32'hA0 || dut_src !== 2'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL burst_beat0 grant=%b data=%h src=%0d busy=%b exp 0001/a0/0/1",
                      grant, dut_data, dut_src, busy);
    end
    @(negedge clk);
    total++;
    if (dut_data !== 32'hA1) begin bad++; $display("FAIL burst_beat1 data=%h exp=a1", dut_data); end
    @(negedge clk);
    total++;
    if (dut_data !== 32'hA2 || dut_last !== 1'b1) begin
      bad++; $display("FAIL burst_beat2 data=%h last=%b exp a2/1", dut_data, dut_last);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || grant !== '0) begin
      bad++; $display("FAIL burst_end busy=%b grant=%b exp 0/0000", busy, grant);
    end
  endtask

  task automatic test_ready_toggle();
    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int x0;
    logic [DATA_W-1:0] prev;
    dut_ready = 1'b1;
    @(posedge clk); #2;
    for (int k = 0; k < 4; k++) push_beat(2, DATA_W'(32'hC0 + k), k == 3, 1'b1);
    exp_grant_q.push_back(4'b0100);
    x0 = xfer_cnt;
    wait_busy("ready_toggle");
    @(negedge clk);
    prev = dut_data;
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #2;
      dut_ready = pat[k];
      @(negedge clk);
      if (!pat[k-1]) begin
        total++;
        if (dut_data !== prev) begin
          bad++; $display("FAIL stall_hold cycle=%0d data=%h exp=%h", k, dut_data, prev);
        end
      end
      total++;
      if ((req_ready & 4'b1011) !== '0) begin
        bad++; $display("FAIL nonowner_ready cycle=%0d req_ready=%b exp=0x00", k, req_ready);
      end
      prev = dut_data;
    end
    wait_drain("ready_toggle");
    total++;
    if (xfer_cnt - x0 !== 4) begin
      bad++; $display("FAIL toggle_xfers got=%0d exp=4", xfer_cnt - x0);
    end
    dut_ready = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    dut_ready = 1'b1;
    @(posedge clk); #2;
    for (int k = 0; k < 4; k++) push_beat(1, DATA_W'(32'hB0 + k), k == 3, 1'b1);
    exp_grant_q.push_back(4'b0010);
    wait_busy("reset_mid");
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (grant !== '0 || busy !== 1'b0 || dut_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset grant=%b busy=%b valid=%b exp 0000/0/0", grant, busy, dut_valid);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_q[i].delete();
      exp_q[i].delete();
      hold[i] = 1'b0;
    end
    exp_grant_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    for (int r = 0; r < NUM_REQ; r++) push_beat(r, DATA_W'(32'h200 + r), 1'b1, 1'b1);
    exp_grant_q.push_back(4'b0001);
    exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100);
    exp_grant_q.push_back(4'b1000);
    wait_drain("reset_mid");
    total++;
    if (exp_grant_q.size() !== 0) begin
      bad++; $display("FAIL post_reset_grants_left got=%0d exp=0", exp_grant_q.size());
      exp_grant_q.delete();
    end
  endtask

  task automatic test_no_preempt();
    int x0;
    bit ok = 1'b1;
    dut_ready = 1'b1;
    @(posedge clk); #2;
    push_beat(3, 32'hD0, 1'b0, 1'b1);
    push_beat(3, 32'hD1, 1'b0, 1'b1);
    push_beat(3, 32'hD2, 1'b1, 1'b1);
    exp_grant_q.push_back(4'b1000);
    exp_grant_q.push_back(4'b0001);
    wait_busy("no_preempt");
    hold[3] = 1'b1;
    push_beat(0, 32'hE0, 1'b1, 1'b1);
    x0 = xfer_cnt;
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      if (grant !== 4'b1000) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL preempt grant=%b exp=1000", grant); end
    total++;
    if (xfer_cnt - x0 !== 1) begin
      bad++; $display("FAIL stall_xfers got=%0d exp=1", xfer_cnt - x0);
    end
    hold[3] = 1'b0;
    wait_drain("no_preempt");
    total++;
    if (exp_grant_q.size() !== 0) begin
      bad++; $display("FAIL preempt_grants_left got=%0d exp=0", exp_grant_q.size());
      exp_grant_q.delete();
    end
  endtask

`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int to0;
    int k = 0;
    dut_ready = 1'b1;
    @(posedge clk); #2;
    push_beat(1, 32'hF0, 1'b0, 1'b1);
    push_beat(1, 32'hF1, 1'b1, 1'b0);
    exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0100);
    wait_busy("timeout");
    hold[1] = 1'b1;
    push_beat(2, 32'h6_0, 1'b1, 1'b1);
    to0 = to_pulses;
    @(negedge clk);
    // F0 moves on the next edge; the pulse is asserted 8 edges after it.
    for (int c = 0; c < 20 && k == 0; c++) begin
      @(negedge clk);
      if (timeout_err) k = c + 1;
    end
    total++;
    if (k !== 9) begin bad++; $display("FAIL timeout_delay got=%0d exp=9", k); end
    wait_drain("timeout");
    total++;
    if (to_pulses - to0 !== 1) begin
      bad++; $display("FAIL timeout_pulses got=%0d exp=1", to_pulses - to0);
    end
    total++;
    if (exp_grant_q.size() !== 0) begin
      bad++; $display("FAIL timeout_grants_left got=%0d exp=0", exp_grant_q.size());
      exp_grant_q.delete();
    end
    beat_q[1].delete();
    hold[1] = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      hold[i] = 1'b0;
      xfer_s[i] = 1'b0;
    end
    test_reset();
    test_round_robin();
    test_single_burst();
    test_ready_toggle();
    test_reset_mid_burst();
    test_no_preempt();
`ifdef KVT_PROJ_NAME_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
